conv_pool_mc: RTL and testbench

Parametrised multi-kernel successor to the single-block conv/pool engine. On `start` it streams `blk_count` 4x4 image blocks from the input buffer, convolves each block with `NUM_KERNELS` 3x3 kernels, pools the four 2x2 conv results to one pixel per kernel, and writes one byte per kernel per block to the output buffers. Beyond the previous engine it adds:
- a run-length-controlled start/busy/done FSM;
- output back-pressure;
- kernel/shift latching;
- ReLU and saturation;
- optional average pooling.

---
 rtl/conv_pool_mc.sv | 219 +++++++++++++++++++++
 tb/tb_conv_pool_mc.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pool_mc.sv
// conv_pool_mc: streams 4x4 blocks, convolves with NUM_KERNELS 3x3 kernels, pools 2x2 to one byte per kernel.
// Latency: output_we 5 cycles after input_re, 1 block/cycle; `define CONV_POOL_AVG_EN adds average pooling.
// Backpressure: out_stall freezes read counter and all stages, masks input_re, holds y/output_addr.
module conv_pool_mc #(
  parameter int NUM_KERNELS = 3,
  parameter int ADDR_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_W:0]          blk_count,
  input  logic [NUM_KERNELS*72-1:0] conv_kernel,
  input  logic [1:0]               shift,
  input  logic                     pool_mode,
  output logic                     input_re,
  output logic [ADDR_W-1:0]        input_addr,
  input  logic [127:0]             image_4x4,
  input  logic                     out_stall,
  output logic                     output_we,
  output logic [ADDR_W-1:0]        output_addr,
  output logic [NUM_KERNELS*8-1:0] y,
  output logic                     busy,
  output logic                     done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]                state;
  logic [ADDR_W:0]           rd_cnt;
  logic [ADDR_W:0]           cnt_lat;
  logic [NUM_KERNELS*72-1:0] kern_lat;
  logic [1:0]                shift_lat;
  logic                      adv;

  logic                      v0, v1, v2, v3, v4;
  logic [ADDR_W-1:0]         a0, a1, a2, a3;

  logic [127:0]              pix;
  logic [9*17-1:0]           prod [NUM_KERNELS][4];
  logic [4*20-1:0]           csum [NUM_KERNELS];
  logic [NUM_KERNELS*8-1:0]  y_nxt;

`ifdef CONV_POOL_AVG_EN
  logic                      mode_lat;
`else
  logic                      unused_pool_mode;
  assign unused_pool_mode = pool_mode;
`endif

  assign adv        = ~out_stall;
  assign input_re   = (state == S_RUN) & ~out_stall;
  assign input_addr = rd_cnt[ADDR_W-1:0];
  assign output_we  = v4 & ~out_stall;
  assign busy       = (state == S_RUN) | (state == S_DRAIN);
  assign done       = (state == S_DONE);

  function automatic logic signed [16:0] mul(input logic [7:0] w, input logic [7:0] p);
    logic signed [16:0] ws;
    logic signed [16:0] ps;
    ws = {{9{w[7]}}, w};
    ps = {9'd0, p};
    return ws * ps;
  endfunction

  function automatic logic signed [19:0] sum9(input logic [9*17-1:0] pv);
    logic signed [19:0] acc;
    logic [16:0]        p;
    acc = '0;
    for (int t = 0; t < 9; t++) begin
      p   = pv[t*17 +: 17];
      acc = acc + {{3{p[16]}}, p};
    end
    return acc;
  endfunction

  function automatic logic signed [19:0] pool_max(input logic [79:0] cv);
    logic signed [19:0] m;
    logic signed [19:0] c;
    m = cv[19:0];
    for (int q = 1; q < 4; q++) begin
      c = cv[q*20 +: 20];
      if (c > m) m = c;
    end
    return m;
  endfunction

`ifdef CONV_POOL_AVG_EN
  // 22-bit sum keeps the floor-divide exact for the full conv range
  function automatic logic signed [19:0] pool_avg(input logic [79:0] cv);
    logic signed [21:0] s;
    logic [19:0]        c;
    s = '0;
    for (int q = 0; q < 4; q++) begin
      c = cv[q*20 +: 20];
      s = s + {{2{c[19]}}, c};
    end
    s = s >>> 2;
    return s[19:0];
  endfunction
`endif

  function automatic logic [7:0] post(input logic signed [19:0] v, input logic [1:0] sh);
    logic [19:0] u;
    u = v[19] ? '0 : v;
    u = u >> {sh, 1'b0};
    return (u > 20'd255) ? 8'hFF : u[7:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rd_cnt    <= '0;
      cnt_lat   <= '0;
      kern_lat  <= '0;
      shift_lat <= '0;
`ifdef CONV_POOL_AVG_EN
      mode_lat  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt_lat   <= blk_count;
            kern_lat  <= conv_kernel;
            shift_lat <= shift;
`ifdef CONV_POOL_AVG_EN
            mode_lat  <= pool_mode;
`endif
            rd_cnt    <= '0;
            state     <= (blk_count == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (adv) begin
            rd_cnt <= rd_cnt + CNT_ONE;
            if (rd_cnt == cnt_lat - CNT_ONE) state <= S_DRAIN;
          end
        end
        // leave once the final write is being accepted this cycle
        S_DRAIN: begin
          if (adv && !(v0 | v1 | v2 | v3)) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0          <= 1'b0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      v3          <= 1'b0;
      v4          <= 1'b0;
      a0          <= '0;
      a1          <= '0;
      a2          <= '0;
      a3          <= '0;
      output_addr <= '0;
      y           <= '0;
    end else if (adv) begin
      v0 <= input_re;
      a0 <= input_addr;
      v1 <= v0;
      a1 <= a0;
      v2 <= v1;
      a2 <= a1;
      v3 <= v2;
      a3 <= a2;
      v4 <= v3;
      if (v3) begin
        output_addr <= a3;
        y           <= y_nxt;
      end
    end
  end

  // datapath needs no reset; stages only load behind a valid token
  always_ff @(posedge clk) begin
    if (adv) begin
      if (v0) pix <= image_4x4;
      if (v1) begin
        for (int k = 0; k < NUM_KERNELS; k++) begin
          for (int q = 0; q < 4; q++) begin
            for (int t = 0; t < 9; t++) begin
              prod[k][q][t*17 +: 17] <= mul(kern_lat[k*72 + t*8 +: 8],
                pix[((q/2 + t/3)*4 + (q%2) + (t%3))*8 +: 8]);
            end
          end
        end
      end
      if (v2) begin
        for (int k = 0; k < NUM_KERNELS; k++) begin
          for (int q = 0; q < 4; q++) begin
            csum[k][q*20 +: 20] <= sum9(prod[k][q]);
          end
        end
      end
    end
  end

  always_comb begin
    y_nxt = '0;
    for (int k = 0; k < NUM_KERNELS; k++) begin
`ifdef CONV_POOL_AVG_EN
      y_nxt[k*8 +: 8] = post(mode_lat ? pool_avg(csum[k]) : pool_max(csum[k]), shift_lat);
`else
      y_nxt[k*8 +: 8] = post(pool_max(csum[k]), shift_lat);
`endif
    end
  end

endmodule

// File: tb/tb_conv_pool_mc.sv
// Scoreboard bench for conv_pool_mc: directed runs push expected writes, a negedge monitor pops and compares.
module tb_conv_pool_mc;
  localparam int NK = 3;
  localparam int AW = 4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [AW:0]       blk_count;
  logic [NK*72-1:0]  conv_kernel;
  logic [1:0]        shift;
  logic              pool_mode;
  logic              input_re;
  logic [AW-1:0]     input_addr;
  logic [127:0]      image_4x4;
  logic              out_stall;
  logic              output_we;
  logic [AW-1:0]     output_addr;
  logic [NK*8-1:0]   y;
  logic              busy;
  logic              done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [127:0] img_mem [16];
  logic [23:0]  exp_tbl [16];
  logic [27:0]  sb [$];
  int reads, writes, first_re_cyc, first_we_cyc, last_we_cyc, done_cyc, start_cyc;
  int stall_from = -1;
  int stall_len = 0;
  bit done_seen;
  logic [AW-1:0] ra;

  conv_pool_mc #(.NUM_KERNELS(NK), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .blk_count(blk_count),
    .conv_kernel(conv_kernel), .shift(shift), .pool_mode(pool_mode),
    .input_re(input_re), .input_addr(input_addr), .image_4x4(image_4x4),
    .out_stall(out_stall), .output_we(output_we), .output_addr(output_addr),
    .y(y), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // input buffer: data appears in the cycle after input_re and holds until the next read
  initial begin
    image_4x4 = '0;
    forever begin
      @(negedge clk);
      if (input_re === 1'b1) begin
        ra = input_addr;
        @(posedge clk);
        #1;
        image_4x4 = img_mem[ra];
      end
    end
  end

  initial begin
    out_stall = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_stall = (stall_from >= 0) && (cyc >= stall_from) && (cyc < stall_from + stall_len);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (input_re) begin
        reads++;
        if (first_re_cyc < 0) first_re_cyc = cyc;
      end
      if (out_stall) chk("input_re_in_stall", input_re, 0);
      if (output_we) begin
        writes++;
        if (first_we_cyc < 0) first_we_cyc = cyc;
        last_we_cyc = cyc;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr=%0d y=%06h, expected no write", output_addr, y);
        end else begin
          chk("write_addr_y", {output_addr, y}, sb.pop_front());
        end
      end
      if (done) begin
        done_seen = 1'b1;
        done_cyc = cyc;
        chk("busy_at_done", busy, 0);
      end
    end
  end

  function automatic logic [71:0] kern_all(input logic [7:0] w);
    return {9{w}};
  endfunction

  function automatic logic [71:0] kern_one(input int idx, input logic [7:0] w);
    logic [71:0] k;
    k = '0;
    k[idx*8 +: 8] = w;
    return k;
  endfunction

  task automatic fill_const(input logic [7:0] v);
    for (int b = 0; b < 16; b++) img_mem[b] = {16{v}};
  endtask

  task automatic fill_ramp();
    for (int b = 0; b < 16; b++) img_mem[b] = {16{8'(b + 1)}};
  endtask

  task automatic do_run(input int n, input logic [NK*72-1:0] kern, input logic [1:0] sh,
                        input logic pm, input int stall_off, input int slen);
    logic [3:0] a;
    for (int b = 0; b < n; b++) begin
      a = b[3:0];
      sb.push_back({a, exp_tbl[b]});
    end
    @(posedge clk);
    #1;
    conv_kernel = kern;
    shift = sh;
    pool_mode = pm;
    blk_count = n[AW:0];
    reads = 0;
    writes = 0;
    first_re_cyc = -1;
    first_we_cyc = -1;
    last_we_cyc = -100;
    done_seen = 1'b0;
    start = 1'b1;
    start_cyc = cyc;
    stall_len = slen;
    if (slen > 0) stall_from = start_cyc + stall_off;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", busy, (n != 0));
    for (int i = 0; i < 300 && !done_seen; i++) @(posedge clk);
    chk("done_seen", done_seen, 1);
    chk("done_cycle", done_cyc, (n == 0) ? start_cyc + 1 : last_we_cyc + 1);
    chk("read_count", reads, n);
    chk("write_count", writes, n);
    chk("scoreboard_empty", sb.size(), 0);
    if (n > 0) chk("first_read_cycle", first_re_cyc, start_cyc + 1);
    if (n > 0 && slen == 0) chk("first_write_latency", first_we_cyc - first_re_cyc, 5);
    stall_from = -1;
    stall_len = 0;
    sb.delete();
  endtask

  int v;
  int w_snap;

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    blk_count = '0;
    conv_kernel = '0;
    shift = '0;
    pool_mode = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outputs", {input_re, output_we, busy, done, input_addr, output_addr, y}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("idle_outputs", {input_re, output_we, busy, done, output_addr, y}, 0);

    // all ones; a second start mid-run with new settings must be ignored
    fill_const(8'd1);
    for (int b = 0; b < 4; b++) exp_tbl[b] = 24'h090909;
    fork
      do_run(4, {3{kern_all(8'd1)}}, 2'd0, 1'b0, 0, 0);
      begin
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        blk_count = 5'd7;
        conv_kernel = '1;
        shift = 2'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    join

    // pooling pattern: k0 w00=1, k1 w22=1, k2 w01=2
    img_mem[0] = '0;
    img_mem[0][7:0] = 8'd4;
    img_mem[0][15:8] = 8'd8;
    img_mem[0][39:32] = 8'd12;
    img_mem[0][47:40] = 8'd16;
    exp_tbl[0] = 24'h200010;
    do_run(1, {kern_one(1, 8'd2), kern_one(8, 8'd1), kern_one(0, 8'd1)}, 2'd0, 1'b0, 0, 0);
`ifdef CONV_POOL_AVG_EN
    exp_tbl[0] = 24'h0C000A;
`else
    exp_tbl[0] = 24'h200010;
`endif
    do_run(1, {kern_one(1, 8'd2), kern_one(8, 8'd1), kern_one(0, 8'd1)}, 2'd0, 1'b1, 0, 0);

    // saturation and ReLU with full-scale pixels
    fill_const(8'd255);
    exp_tbl[0] = 24'h0000FF;
    exp_tbl[1] = 24'h0000FF;
    do_run(2, {kern_one(4, 8'hFF), kern_all(8'h80), kern_all(8'h7F)}, 2'd3, 1'b0, 0, 0);

    fill_const(8'd10);
    exp_tbl[0] = 24'hFF5A00;
    exp_tbl[1] = 24'hFF5A00;
    do_run(2, {kern_all(8'h7F), kern_all(8'h01), kern_one(4, 8'hFF)}, 2'd0, 1'b0, 0, 0);

    exp_tbl[0] = 24'h000B05;
    exp_tbl[1] = 24'h000B05;
    do_run(2, {kern_one(0, 8'h01), kern_all(8'h02), kern_all(8'h01)}, 2'd2, 1'b0, 0, 0);

    // full address space with a 3-cycle stall mid-run
    fill_ramp();
    for (int b = 0; b < 16; b++) exp_tbl[b] = {8'(2 * (b + 1)), 8'(9 * (b + 1)), 8'(b + 1)};
    do_run(16, {kern_one(0, 8'd1) | kern_one(1, 8'd1), kern_all(8'd1), kern_one(0, 8'd1)},
           2'd0, 1'b0, 6, 3);

    // stall lands on the final read
    fill_const(8'd1);
    for (int b = 0; b < 3; b++) exp_tbl[b] = 24'h090909;
    do_run(3, {3{kern_all(8'd1)}}, 2'd0, 1'b0, 3, 2);

    do_run(0, {3{kern_all(8'd1)}}, 2'd0, 1'b0, 0, 0);

    // abort mid-run with reset
    fill_ramp();
    for (int b = 0; b < 16; b++) begin
      v = 18 * (b + 1);
      if (v > 255) v = 255;
      sb.push_back({b[3:0], {3{8'(v)}}});
    end
    @(posedge clk);
    #1;
    conv_kernel = {3{kern_all(8'd2)}};
    shift = 2'd0;
    blk_count = 5'd16;
    writes = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_outputs", {input_re, output_we, busy, done, input_addr, output_addr, y}, 0);
    chk("writes_before_abort", writes, 2);
    sb.delete();
    w_snap = writes;
    done_seen = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    chk("no_write_after_abort", writes, w_snap);
    chk("no_done_after_abort", done_seen, 0);

    for (int b = 0; b < 4; b++) exp_tbl[b] = {3{8'(9 * (b + 1))}};
    do_run(4, {3{kern_all(8'd1)}}, 2'd0, 1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
